// File: rtl/rr_arbiter_4x1_pkg.sv
// Shared types, sizes and round-robin search helper
// for the 4-way arbiter slice.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef logic [0:0] state_t;
    localparam state_t IDLE  = 1'b0;
    localparam state_t GRANT = 1'b1;

    // Nearest set bit after 'from', wrapping; 'from' itself ranks last.
    function automatic logic [SEL_W-1:0] next_rr(
        input logic [N_REQ-1:0] req,
        input logic [SEL_W-1:0] from
    );
        logic [SEL_W-1:0] idx;
        next_rr = from;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = from + SEL_W'(i);
            if (req[idx]) next_rr = idx;
        end
    endfunction

endpackage

// File: rtl/rr_arbiter_4x1_if.sv
// Request/data in, grant/select/data out bundle
// between requesters and the arbiter.
interface rr_arbiter_4x1_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] y;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             valid;
    logic             out;

    modport master (
        output req, y,
        input  gnt, sel, valid, out
    );

    modport slave (
        input  req, y,
        output gnt, sel, valid, out
    );

endinterface

// File: rtl/rr_arbiter_4x1_mux.sv
// Dataflow 4:1 bit mux shared by the four requesters.
// Purely combinational; the arbiter drives its select.
module mux_4x1
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] y,
    input  logic [SEL_W-1:0] sel,
    output logic             out
);

    assign out = y[sel];

endmodule

// File: rtl/rr_arbiter_4x1.sv
// Round-robin arbiter with bounded tenure, sequencing
// a shared 4:1 mux.
module rr_arbiter_4x1
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_arbiter_4x1_if.slave  bus
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);

    state_t           state;
    logic [SEL_W-1:0] last;
    logic [SEL_W-1:0] sel_q;
    logic [N_REQ-1:0] gnt_q;
    logic             valid_q;
    logic [HW-1:0]    hold_cnt;

    logic             own_req;
    logic             at_limit;
    logic             others;
    logic [SEL_W-1:0] win;
    logic             mux_out;

    assign own_req  = bus.req[sel_q];
    assign at_limit = (hold_cnt == HOLD_LIM);
    assign others   = |(bus.req & ~gnt_q);
    // In GRANT, last always equals sel, so one search serves both states.
    assign win      = next_rr(bus.req, last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt_q    <= '0;
            sel_q    <= '0;
            valid_q  <= 1'b0;
            last     <= SEL_W'(N_REQ - 1);
            hold_cnt <= '0;
        end else if (state == IDLE) begin
            if (|bus.req) begin
                state    <= GRANT;
                gnt_q    <= N_REQ'(1) << win;
                sel_q    <= win;
                last     <= win;
                valid_q  <= 1'b1;
                hold_cnt <= '0;
            end
        end else begin
            priority case (1'b1)
                own_req && !at_limit: begin
                    hold_cnt <= hold_cnt + HW'(1);
                end
                others: begin
                    gnt_q    <= N_REQ'(1) << win;
                    sel_q    <= win;
                    last     <= win;
                    hold_cnt <= '0;
                end
                own_req: begin
                    hold_cnt <= '0;
                end
                default: begin
                    state    <= IDLE;
                    gnt_q    <= '0;
                    valid_q  <= 1'b0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    mux_4x1 u_mux (
        .y   (bus.y),
        .sel (sel_q),
        .out (mux_out)
    );

    assign bus.gnt   = gnt_q;
    assign bus.sel   = sel_q;
    assign bus.valid = valid_q;
    assign bus.out   = mux_out & valid_q;

endmodule
